// File: rtl/hc595_pkg.sv
// hc595_pkg: shared state encoding and tick-count helpers for the 74HC595 scan driver
package hc595_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, BLANK, LATCH, HOLD} state_t;

    function automatic int shift_ticks(input int chain_bits);
        return 2 * chain_bits;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/hc595_scan_driver_tick_gen.sv
// tick_gen: prescaler that strobes tick once every CLK_DIV clocks
module tick_gen #(
    parameter int CLK_DIV = 4
)(
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0] pres;

    assign tick = pres == PW'(CLK_DIV - 1);

    // free-running prescaler, wraps after the tick clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pres <= '0;
        else        pres <= tick ? '0 : pres + 1'b1;
    end
endmodule

// File: rtl/hc595_scan_driver.sv
// hc595_scan_driver: row-scanning driver for a daisy-chained 74HC595 display
module hc595_scan_driver
    import hc595_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int CHAIN_BITS  = 24,
    parameter int ROWS        = 8,
    parameter int BLANK_TICKS = 2,
    parameter int ON_TICKS    = 64
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic [$clog2(ROWS)-1:0] row_addr,
    input  logic [CHAIN_BITS-1:0]   row_data,
    output logic                    ds,
    output logic                    shcp,
    output logic                    stcp,
    output logic                    oe,
    output logic [$clog2(ROWS)-1:0] row_sel,
    output logic                    frame_done
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(max3(shift_ticks(CHAIN_BITS), BLANK_TICKS, ON_TICKS));
    localparam logic [CW-1:0] SHIFT_LAST = CW'(shift_ticks(CHAIN_BITS) - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(ON_TICKS - 1);
    localparam logic [RW-1:0] R_LAST     = RW'(ROWS - 1);

    logic                  tick;
    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [RW-1:0]         r, r_d, row_addr_d, row_sel_d;
    logic [CHAIN_BITS-1:0] sreg, sreg_d;
    logic                  abort_q, abort_d;
    logic                  ds_d, shcp_d, stcp_d, oe_d, frame_done_d;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // state, counters and every pin are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            r          <= '0;
            sreg       <= '0;
            abort_q    <= 1'b0;
            row_addr   <= '0;
            row_sel    <= '0;
            ds         <= 1'b0;
            shcp       <= 1'b0;
            stcp       <= 1'b0;
            oe         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            r          <= r_d;
            sreg       <= sreg_d;
            abort_q    <= abort_d;
            row_addr   <= row_addr_d;
            row_sel    <= row_sel_d;
            ds         <= ds_d;
            shcp       <= shcp_d;
            stcp       <= stcp_d;
            oe         <= oe_d;
            frame_done <= frame_done_d;
        end
    end

    // next state and pin values; a dropped en blanks at once and is remembered until the tick
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        r_d          = r;
        sreg_d       = sreg;
        abort_d      = abort_q | ~en;
        row_addr_d   = row_addr;
        row_sel_d    = row_sel;
        ds_d         = ds;
        shcp_d       = shcp;
        stcp_d       = stcp;
        oe_d         = oe;
        frame_done_d = 1'b0;
        if (tick) begin
            abort_d = 1'b0;
            if (!en || abort_q) begin
                state_d = IDLE;
                cnt_d   = '0;
                oe_d    = 1'b1;
                shcp_d  = 1'b0;
                stcp_d  = 1'b0;
            end else begin
                cnt_d = cnt + 1'b1;
                case (state)
                    IDLE: begin
                        state_d    = FETCH;
                        cnt_d      = '0;
                        r_d        = '0;
                        row_addr_d = '0;
                    end
                    FETCH: begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        ds_d    = row_data[CHAIN_BITS-1];
                        sreg_d  = row_data << 1;
                        shcp_d  = 1'b0;
                    end
                    SHIFT: begin
                        if (cnt == SHIFT_LAST) begin
                            state_d = BLANK;
                            cnt_d   = '0;
                            shcp_d  = 1'b0;
                            oe_d    = 1'b1;
                        end else if (!cnt[0]) begin
                            shcp_d = 1'b1;
                        end else begin
                            shcp_d = 1'b0;
                            ds_d   = sreg[CHAIN_BITS-1];
                            sreg_d = sreg << 1;
                        end
                    end
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state_d      = LATCH;
                            cnt_d        = '0;
                            stcp_d       = 1'b1;
                            row_sel_d    = r;
                            frame_done_d = r == R_LAST;
                        end
                    end
                    LATCH: begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        stcp_d  = 1'b0;
                        oe_d    = 1'b0;
                        r_d     = (r == R_LAST) ? '0 : r + 1'b1;
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state_d    = FETCH;
                            cnt_d      = '0;
                            row_addr_d = r;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (!en) begin
            oe_d   = 1'b1;
            shcp_d = 1'b0;
            stcp_d = 1'b0;
        end
    end
endmodule
